// File: rtl/uart_frame_instr_loader.sv
// Framed, checksummed UART instruction loader with ACK/NAK response.
// Ports: clk/rst, rx_byte/rx_done/rx_parity_err in, tx_byte/tx_en/tx_busy,
//   wr_en/wr_addr/wr_data to imem, loading/frame_done/last_err/frame_count status.
module uart_frame_instr_loader #(
  parameter int INSTR_WIDTH    = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_BYTES     = 2,
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_CYCLES = 500000,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_done,
  input  logic                   rx_parity_err,
  output logic [7:0]             tx_byte,
  output logic                   tx_en,
  input  logic                   tx_busy,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   loading,
  output logic                   frame_done,
  output logic [2:0]             last_err,
  output logic [15:0]            frame_count
);

  localparam int BPW = INSTR_WIDTH / 8;
  localparam int AXW = 8 * ADDR_BYTES;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int HBW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int SW  = ((AXW > 16) ? AXW : 16) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RESP
  } state_t;

  state_t                 state;
  logic [AXW-1:0]         addr;
  logic [15:0]            count;
  logic [15:0]            word_idx;
  logic [HBW-1:0]         hdr_cnt;
  logic                   len_cnt;
  logic [BIW-1:0]         bidx;
  logic [INSTR_WIDTH-1:0] shreg;
  logic [7:0]             csum;
  logic [2:0]             err;
  logic [TW-1:0]          timer;

  logic [7:0]             sum_n;
  logic [15:0]            count_n;
  logic                   range_bad;
  logic [BIW-1:0]         byte_pos;
  logic [INSTR_WIDTH-1:0] word_n;
  logic                   last_byte;
  logic                   last_word;
  logic [2:0]             err_n;
  logic                   supp;

  always_comb begin
    sum_n     = csum + rx_byte;
    count_n   = {count[7:0], rx_byte};
    range_bad = (SW'(addr) >= SW'(DEPTH)) ||
                (SW'(addr) + SW'(count_n) > SW'(DEPTH));
    byte_pos  = (BIG_ENDIAN != 0) ? (BIW'(BPW - 1) - bidx) : bidx;
    word_n    = shreg;
    word_n[byte_pos*8 +: 8] = rx_byte;
    last_byte = (bidx == BIW'(BPW - 1));
    last_word = (word_idx == count - 16'd1);
    // Higher error codes overwrite lower ones; checksum applies to a clean frame only.
    err_n = err;
    if (state == S_LEN && len_cnt && range_bad && err < 3'd2)
      err_n = 3'd2;
    if (state == S_CSUM && sum_n != 8'd0 && err == 3'd0)
      err_n = 3'd1;
    if (rx_parity_err && err_n < 3'd3)
      err_n = 3'd3;
    supp = (err_n == 3'd2) || (err_n == 3'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      count       <= '0;
      word_idx    <= '0;
      hdr_cnt     <= '0;
      len_cnt     <= 1'b0;
      bidx        <= '0;
      shreg       <= '0;
      csum        <= '0;
      err         <= '0;
      timer       <= '0;
      tx_byte     <= '0;
      tx_en       <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      loading     <= 1'b0;
      frame_done  <= 1'b0;
      last_err    <= '0;
      frame_count <= '0;
    end else begin
      wr_en      <= 1'b0;
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_done && rx_byte == 8'hA5) begin
            state    <= S_ADDR;
            loading  <= 1'b1;
            csum     <= '0;
            err      <= '0;
            word_idx <= '0;
            bidx     <= '0;
            hdr_cnt  <= '0;
            len_cnt  <= 1'b0;
            timer    <= '0;
            addr     <= '0;
            count    <= '0;
          end
        end
        S_RESP: begin
          if (!tx_busy) begin
            tx_en      <= 1'b1;
            tx_byte    <= (err == 3'd0) ? 8'h06 : {5'b00010, err};
            frame_done <= 1'b1;
            last_err   <= err;
            if (err == 3'd0)
              frame_count <= frame_count + 16'd1;
            loading    <= 1'b0;
            timer      <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          // A byte arriving on the expiry cycle takes precedence.
          if (rx_done) begin
            timer <= '0;
            csum  <= sum_n;
            err   <= err_n;
            case (state)
              S_ADDR: begin
                addr    <= AXW'({addr, rx_byte});
                hdr_cnt <= hdr_cnt + HBW'(1);
                if (hdr_cnt == HBW'(ADDR_BYTES - 1))
                  state <= S_LEN;
              end
              S_LEN: begin
                count   <= count_n;
                len_cnt <= 1'b1;
                if (len_cnt)
                  state <= (count_n == 16'd0) ? S_CSUM : S_DATA;
              end
              S_DATA: begin
                shreg <= word_n;
                if (last_byte) begin
                  bidx     <= '0;
                  word_idx <= word_idx + 16'd1;
                  if (!supp) begin
                    wr_en   <= 1'b1;
                    wr_addr <= AW'(SW'(addr) + SW'(word_idx));
                    wr_data <= word_n;
                  end
                  if (last_word)
                    state <= S_CSUM;
                end else begin
                  bidx <= bidx + BIW'(1);
                end
              end
              S_CSUM: state <= S_RESP;
              default: ;
            endcase
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            err   <= 3'd4;
            state <= S_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
      endcase
    end
  end

endmodule
